amoa_seq_ctrl: RTL and testbench
================================

AMOA_SEQ_CTRL -- requirements
Module: amoa_seq_ctrl

Interface
REQ-001 Parameters SHALL be: W, default 8, number of bit columns per operation; CNT_W, default 8, width of the error counter.
REQ-002 clk  in  1  the only clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begins an operation; sampled only in IDLE.
REQ-005 col_valid  in  1, and col_bits  in  8: col_bits is one bit column of the 8 operands, LSB column first.
REQ-006 col_ready  out  1  column accepted on the cycle where col_valid and col_ready are both 1.
REQ-007 x_bits  out  8  column bits to the ApxRT inputs x1..x8 (bit0 = x1).
REQ-008 cin1_apxrt, cin2_apxrt  out  1 each  carry feedback to the ApxRT.
REQ-009 cin_ec, carryin_ec  out  1 each  EC8 compensation inputs.
REQ-010 stall  out  1  CPA hold.
REQ-011 cout1_apxrt, cout2_apxrt, error  in  1 each  outputs returned by the datapath.
REQ-012 busy  out  1, done  out  1, col_idx  out  $clog2(W+1), err_cnt  out  CNT_W  status outputs.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-014 IDLE->RUN SHALL occur on start=1.
REQ-015 RUN->FLUSH SHALL occur on the handshake of the column where col_idx=W-1.
REQ-016 FLUSH SHALL last exactly FLUSH_CYCLES=2 cycles and then go to DONE.
REQ-017 DONE SHALL last 1 cycle and then go to IDLE.
REQ-018 col_ready SHALL be 1 only in RUN.
REQ-019 x_bits SHALL equal col_bits when col_valid=1 in RUN, and 0 otherwise, including all of FLUSH.
REQ-020 stall SHALL be 1 in IDLE, in DONE, and in any RUN cycle with col_valid=0; stall SHALL be 0 in FLUSH and on RUN handshake cycles.
REQ-021 On each handshake and on each FLUSH cycle, cin1_apxrt and cin2_apxrt SHALL be registered from cout1_apxrt and cout2_apxrt (1-cycle carry chaining).
REQ-022 On cycles with stall=1, cin1_apxrt and cin2_apxrt SHALL hold their values.
REQ-023 On the IDLE->RUN transition, cin1_apxrt and cin2_apxrt SHALL be cleared to 0.
REQ-024 cin_ec SHALL be 1 only while col_idx=0 in RUN.
REQ-025 carryin_ec SHALL be error registered on the previous advancing cycle, and SHALL be cleared at start.
REQ-026 col_idx SHALL increment by 1 per handshake, clear at start, and not wrap: its maximum value is W, reached after the last column.
REQ-027 err_cnt SHALL increment on each advancing cycle (handshake or FLUSH) where error=1, and SHALL saturate at 2^CNT_W-1.
REQ-028 err_cnt SHALL clear at start and hold its value through DONE and IDLE until the next start.
REQ-029 busy SHALL be 1 in RUN and FLUSH.
REQ-030 done SHALL be a 1-cycle pulse in DONE.
REQ-031 start outside IDLE, including in the DONE cycle, SHALL be ignored.
REQ-032 col_valid outside RUN SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE; col_idx, err_cnt, cin1_apxrt, cin2_apxrt and carryin_ec to 0; done and busy to 0; stall to 1.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-035 With AMOA_ERR_CNT_EN defined, err_cnt and carryin_ec SHALL behave as specified above.
REQ-036 Without AMOA_ERR_CNT_EN, err_cnt and carryin_ec SHALL be constant 0, the error input SHALL be unused, and no counter flops SHALL be built.

Structure
REQ-037 Package amoa_ctrl_pkg SHALL hold the state enum and FLUSH_CYCLES=2.
REQ-038 Sub-module amoa_err_cnt SHALL implement the saturating counter, instantiated only under AMOA_ERR_CNT_EN.

Verification
REQ-039 After reset, with no start: stall=1, busy=0, err_cnt=0 and col_ready=0.
REQ-040 W=8, start, then 8 back-to-back columns: col_ready is high 8 cycles, busy is high for 10 cycles (8 RUN + 2 FLUSH), then done pulses once, and col_idx=8.
REQ-041 col_valid=0 for 3 cycles mid-RUN: stall=1 and cin1/cin2 and col_idx are frozen for exactly those 3 cycles.
REQ-042 cout1=1 and cout2=0 on column 3: the cin1_apxrt=1, cin2_apxrt=0 pair is presented on the next advancing cycle.
REQ-043 error=1 on all 10 advancing cycles with CNT_W=3: err_cnt saturates at 7; without the macro, err_cnt stays 0.
REQ-044 rst_n pulsed low at column 4, then start with 8 columns: no done pulse for the aborted run, and the new run counts from col_idx=0 with err_cnt=0.

Source files
------------

// File: rtl/amoa_ctrl_pkg.sv
// Shared types and constants for the AMOA column-serial sequencer.
package amoa_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FLUSH_CYCLES = 2;
endpackage

// File: rtl/amoa_err_cnt.sv
// Saturating error counter; cleared at operation start, counts flagged advancing cycles.
module amoa_err_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_r;

   // counter register: clear wins over increment, stop at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;
endmodule

// File: rtl/amoa_seq_ctrl.sv
// Column-serial control for the ApxRT/EC8 multi-operand adder: feeds columns, chains carries, flushes.
// Optional error accounting (err_cnt, carryin_ec) is built only when AMOA_ERR_CNT_EN is defined.
module amoa_seq_ctrl
   import amoa_ctrl_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     col_valid,
   input  logic [7:0]               col_bits,
   output logic                     col_ready,
   output logic [7:0]               x_bits,
   output logic                     cin1_apxrt,
   output logic                     cin2_apxrt,
   output logic                     cin_ec,
   output logic                     carryin_ec,
   output logic                     stall,
   input  logic                     cout1_apxrt,
   input  logic                     cout2_apxrt,
   input  logic                     error,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(W+1)-1:0]   col_idx,
   output logic [CNT_W-1:0]         err_cnt
);
   localparam int CW = $clog2(W + 1);

   state_t          state_r;
   state_t          state_nxt_s;
   logic            flush_cnt_r;
   logic [CW-1:0]   col_idx_r;
   logic            cin1_r;
   logic            cin2_r;
   logic            start_s;
   logic            hs_s;
   logic            adv_s;
   logic            last_col_s;
   logic            flush_end_s;

   // "advancing" = any cycle the datapath consumes a column or a flush slot
   assign start_s     = (state_r == IDLE) && start;
   assign hs_s        = (state_r == RUN) && col_valid;
   assign adv_s       = hs_s || (state_r == FLUSH);
   assign last_col_s  = (col_idx_r == CW'(W - 1));
   assign flush_end_s = (flush_cnt_r == 1'(FLUSH_CYCLES - 1));

   // next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (start) state_nxt_s = RUN; else state_nxt_s = IDLE;
         RUN:     if (hs_s && last_col_s) state_nxt_s = FLUSH; else state_nxt_s = RUN;
         FLUSH:   if (flush_end_s) state_nxt_s = DONE; else state_nxt_s = FLUSH;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // per-state outputs; stall defaults high so the CPA holds unless a column moves
   always_comb begin
      col_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      stall     = 1'b1;
      cin_ec    = 1'b0;
      x_bits    = 8'h00;
      case (state_r)
         RUN: begin
            col_ready = 1'b1;
            busy      = 1'b1;
            cin_ec    = (col_idx_r == CW'(0));
            if (col_valid) begin
               x_bits = col_bits;
               stall  = 1'b0;
            end else begin
               x_bits = 8'h00;
               stall  = 1'b1;
            end
         end
         FLUSH: begin
            busy  = 1'b1;
            stall = 1'b0;
         end
         DONE:    done  = 1'b1;
         IDLE:    stall = 1'b1;
         default: stall = 1'b1;
      endcase
   end

   // state, flush timer, column index and one-cycle carry chaining
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         flush_cnt_r <= 1'b0;
         col_idx_r   <= CW'(0);
         cin1_r      <= 1'b0;
         cin2_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         flush_cnt_r <= (state_r == FLUSH) ? flush_cnt_r + 1'b1 : 1'b0;
         if (start_s) begin
            col_idx_r <= CW'(0);
            cin1_r    <= 1'b0;
            cin2_r    <= 1'b0;
         end else begin
            if (hs_s) col_idx_r <= col_idx_r + CW'(1);
            if (adv_s) begin
               cin1_r <= cout1_apxrt;
               cin2_r <= cout2_apxrt;
            end
         end
      end
   end

   assign cin1_apxrt = cin1_r;
   assign cin2_apxrt = cin2_r;
   assign col_idx    = col_idx_r;

`ifdef AMOA_ERR_CNT_EN
   logic carry_ec_r;

   // EC8 carry-in follows the previous advancing cycle's error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_ec_r <= 1'b0;
      end else if (start_s) begin
         carry_ec_r <= 1'b0;
      end else if (adv_s) begin
         carry_ec_r <= error;
      end else begin
         carry_ec_r <= carry_ec_r;
      end
   end

   amoa_err_cnt #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_s),
      .inc   (adv_s && error),
      .cnt   (err_cnt)
   );

   assign carryin_ec = carry_ec_r;
`else
   logic unused_error_s;
   assign unused_error_s = error;
   assign carryin_ec     = 1'b0;
   assign err_cnt        = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_amoa_seq_ctrl.sv
// Self-checking bench for amoa_seq_ctrl against an operation-level reference model.
module tb_amoa_seq_ctrl;
   localparam int W     = 8;
   localparam int CNT_W = 3;
   localparam int CW    = 4;

   logic clk = 1'b0;
   logic rst_n, start, col_valid, cout1, cout2, error;
   logic [7:0] col_bits;
   logic col_ready, cin1, cin2, cin_ec, carryin_ec, stall, busy, done;
   logic [7:0] x_bits;
   logic [CW-1:0] col_idx;
   logic [CNT_W-1:0] err_cnt;

   int checks = 0;
   int failures = 0;

   // reference model: operation progress in columns consumed and flush slots used
   bit m_active, m_done, m_cin1, m_cin2, m_carry;
   int m_cols, m_flush, m_errs;

   always #5 clk = ~clk;

   amoa_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_bits(col_bits),
      .col_ready(col_ready), .x_bits(x_bits), .cin1_apxrt(cin1), .cin2_apxrt(cin2),
      .cin_ec(cin_ec), .carryin_ec(carryin_ec), .stall(stall),
      .cout1_apxrt(cout1), .cout2_apxrt(cout2), .error(error),
      .busy(busy), .done(done), .col_idx(col_idx), .err_cnt(err_cnt)
   );

   function automatic logic [23:0] obs();
      return {done, busy, stall, col_ready, x_bits, cin1, cin2, cin_ec, carryin_ec, col_idx, err_cnt};
   endfunction

   function automatic logic [23:0] expv();
      bit run, fl, c;
      int e;
      logic [7:0] xb;
      run = m_active && (m_cols < W);
      fl  = m_active && (m_cols == W);
      xb  = (run && col_valid) ? col_bits : 8'h00;
`ifdef AMOA_ERR_CNT_EN
      c = m_carry; e = m_errs;
`else
      c = 1'b0; e = 0;
`endif
      return {m_done, m_active, !(fl || (run && col_valid)), run, xb, m_cin1, m_cin2,
              (run && m_cols == 0), c, 4'(m_cols), 3'(e)};
   endfunction

   task automatic model_reset();
      m_active = 0; m_done = 0; m_cols = 0; m_flush = 0;
      m_cin1 = 0; m_cin2 = 0; m_carry = 0; m_errs = 0;
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic step();
      bit run, fl;
      run = m_active && (m_cols < W);
      fl  = m_active && (m_cols == W);
      if (!m_active && !m_done && start) begin
         m_active = 1; m_cols = 0; m_flush = 0;
         m_cin1 = 0; m_cin2 = 0; m_carry = 0; m_errs = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if ((run && col_valid) || fl) begin
         m_cin1 = cout1; m_cin2 = cout2; m_carry = error;
         if (error && m_errs < (1 << CNT_W) - 1) m_errs++;
         if (run) m_cols++;
         else begin
            m_flush++;
            if (m_flush == 2) begin m_active = 0; m_done = 1; end
         end
      end
   endtask

   task automatic drive(input logic st, input logic cv, input logic [7:0] b,
                        input logic c1, input logic c2, input logic er);
      @(negedge clk);
      start = st; col_valid = cv; col_bits = b; cout1 = c1; cout2 = c2; error = er;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 0; col_valid = 0; col_bits = 0; cout1 = 0; cout2 = 0; error = 0;
      model_reset();
      #1;
      checks++;
      if ({stall, busy, err_cnt, col_ready} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got=%b exp=%b", {stall, busy, err_cnt, col_ready}, 6'b100000);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL idle_no_start cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int n_ready = 0, n_busy = 0, n_done = 0;
      logic [CW-1:0] last_idx;
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== expv()) begin
         failures++; $display("FAIL b2b_start got=%h exp=%h", obs(), expv());
      end
      step();
      for (int i = 0; i < 12; i++) begin
         drive(1'(m_done), 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL b2b cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         n_ready += int'(col_ready); n_busy += int'(busy); n_done += int'(done);
         last_idx = col_idx;
         step();
      end
      checks++;
      if ({n_ready, n_busy, n_done} !== {32'd8, 32'd10, 32'd1} || last_idx !== 4'd8) begin
         failures++;
         $display("FAIL b2b_counts ready=%0d busy=%0d done=%0d idx=%0d exp 8/10/1/8",
                  n_ready, n_busy, n_done, last_idx);
      end
   endtask

   task automatic test_stall_gaps();
      int gap = 0, n_stall_run = 0;
      logic cv;
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 20 && (m_active || m_done); i++) begin
         cv = !(m_cols == 3 && gap < 3);
         if (!cv) gap++;
         drive(1'b0, cv, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL gaps cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         if (col_ready && stall) n_stall_run++;
         step();
      end
      checks++;
      if (n_stall_run != 3 || m_active || m_done) begin
         failures++; $display("FAIL gaps_stall_count got=%0d exp=3", n_stall_run);
      end
   endtask

   task automatic test_carry();
      bit chk = 0;
      bit c3;
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 20 && (m_active || m_done); i++) begin
         c3 = m_active && (m_cols == 3);
         drive(1'b0, 1'b1, 8'($urandom), c3, !c3, 1'b0);
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL carry cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         if (chk) begin
            checks++;
            if ({cin1, cin2} !== 2'b10) begin
               failures++; $display("FAIL carry_col3 got=%b exp=10", {cin1, cin2});
            end
         end
         chk = c3;
         step();
      end
   endtask

   task automatic test_err_sat();
      logic [CNT_W-1:0] sat;
`ifdef AMOA_ERR_CNT_EN
      sat = 3'd7;
`else
      sat = 3'd0;
`endif
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 20 && (m_active || m_done); i++) begin
         drive(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL errsat cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         if (m_done) begin
            checks++;
            if (err_cnt !== sat) begin
               failures++; $display("FAIL errsat_final got=%0d exp=%0d", err_cnt, sat);
            end
         end
         step();
      end
   endtask

   task automatic test_reset_abort();
      int n_done = 0;
      bit first = 1;
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         n_done += int'(done);
         step();
      end
      drive(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({stall, busy, done, col_idx, cin1, cin2} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL abort_reset got=%b exp=100000000", {stall, busy, done, col_idx, cin1, cin2});
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b1);
         n_done += int'(done);
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL abort_hold cyc%0d got=%h exp=%h", i, obs(), expv());
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 20 && (m_active || m_done); i++) begin
         drive(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL abort_rerun cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         if (first) begin
            checks++;
            if ({col_idx, err_cnt} !== {4'd0, 3'd0}) begin
               failures++; $display("FAIL abort_fresh got=%h exp=0", {col_idx, err_cnt});
            end
            first = 0;
         end
         n_done += int'(done);
         step();
      end
      checks++;
      if (n_done != 1) begin
         failures++; $display("FAIL abort_done_count got=%0d exp=1", n_done);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL random cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 0; col_valid = 0; col_bits = 0; cout1 = 0; cout2 = 0; error = 0;
      model_reset();
      test_reset();
      test_back_to_back();
      test_stall_gaps();
      test_carry();
      test_err_sat();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
